// File: rtl/shift_seq_ctrl.sv
// Phase sequencer for the 4-digit shift-register display: rotate, shift-in-0, shift-in-1.
// Optional feature: define SHIFT_SEQ_LOOP_EN to wrap FILL1 back to ROT instead of returning to IDLE.
module shift_seq_ctrl #(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned STEPS    = 4,
    parameter int unsigned CNT_W    = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    output logic       shift_en,
    output logic       direction,
    output logic       mode1,
    output logic       mode2,
    output logic       mode3,
    output logic       busy,
    output logic [1:0] phase,
    output logic [2:0] step_cnt,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROT   = 2'd1,
        ST_FILL0 = 2'd2,
        ST_FILL1 = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [2:0]       STEP_LAST = 3'(STEPS - 1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [2:0]       step_r;
    logic [2:0]       step_nxt_s;
    logic             dir_r;
    logic             dir_nxt_s;
    logic             done_r;
    logic             done_nxt_s;
    logic             busy_s;
    logic             tick_s;

    // Next-state, counter and hand-off logic; stop outranks start and any pending phase advance.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        step_nxt_s  = step_r;
        dir_nxt_s   = dir_r;
        done_nxt_s  = 1'b0;
        busy_s      = (state_r != ST_IDLE);
        tick_s      = busy_s & ~pause & (cnt_r == CNT_LAST);

        if (stop) begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = '0;
            step_nxt_s  = 3'd0;
            dir_nxt_s   = 1'b0;
        end else if (!busy_s) begin
            cnt_nxt_s  = '0;
            step_nxt_s = 3'd0;
            dir_nxt_s  = 1'b0;
            if (start) begin
                state_nxt_s = ST_ROT;
            end else begin
                state_nxt_s = ST_IDLE;
            end
        end else if (tick_s) begin
            cnt_nxt_s = '0;
            if (step_r == STEP_LAST) begin
                step_nxt_s = 3'd0;
                dir_nxt_s  = ~dir_r;
                case (state_r)
                    ST_ROT:   state_nxt_s = ST_FILL0;
                    ST_FILL0: state_nxt_s = ST_FILL1;
                    ST_FILL1: begin
                        // Each program pass starts rotating leftwards again.
                        done_nxt_s = 1'b1;
                        dir_nxt_s  = 1'b0;
`ifdef SHIFT_SEQ_LOOP_EN
                        state_nxt_s = ST_ROT;
`else
                        state_nxt_s = ST_IDLE;
`endif
                    end
                    default:  state_nxt_s = ST_IDLE;
                endcase
            end else begin
                step_nxt_s = step_r + 3'd1;
            end
        end else if (pause) begin
            cnt_nxt_s = cnt_r;
        end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            step_r  <= 3'd0;
            dir_r   <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            step_r  <= step_nxt_s;
            dir_r   <= dir_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    // pause is the only input allowed to reach an output combinationally (via shift_en).
    assign shift_en  = tick_s;
    assign busy      = busy_s;
    assign phase     = state_r;
    assign mode1     = (state_r == ST_ROT);
    assign mode2     = (state_r == ST_FILL0);
    assign mode3     = (state_r == ST_FILL1);
    assign direction = dir_r;
    assign step_cnt  = step_r;
    assign done      = done_r;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Randomized and directed bench for shift_seq_ctrl against an elapsed-time reference model.
module tb_shift_seq_ctrl;

    localparam int TD = 4;
    localparam int ST = 4;

    logic clk = 1'b0;
    logic rst = 1'b0, start = 1'b0, stop = 1'b0, pause = 1'b0;
    logic shift_en, direction, mode1, mode2, mode3, busy, done;
    logic [1:0] phase;
    logic [2:0] step_cnt;
    logic [12:0] vec;

    int total = 0;
    int bad = 0;

    // Model: busy flag, unpaused busy cycles since start, pulses issued this pass.
    bit m_busy = 1'b0;
    bit m_done = 1'b0;
    int m_el = 0;
    int m_pl = 0;

    shift_seq_ctrl #(.TICK_DIV(TD), .STEPS(ST), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .shift_en(shift_en), .direction(direction), .mode1(mode1), .mode2(mode2),
        .mode3(mode3), .busy(busy), .phase(phase), .step_cnt(step_cnt), .done(done)
    );

    always #5 clk = ~clk;

    assign vec = {shift_en, direction, mode1, mode2, mode3, busy, phase, step_cnt, done};

    function automatic logic [12:0] exp_vec();
        int ph;
        logic [2:0] sc;
        logic se;
        ph = m_busy ? 1 + m_pl / ST : 0;
        sc = m_busy ? 3'(m_pl % ST) : 3'd0;
        se = m_busy && !pause && (m_el % TD == TD - 1);
        return {se, (ph == 2), (ph == 1), (ph == 2), (ph == 3), m_busy, 2'(ph), sc, m_done};
    endfunction

    // Drive one clock edge and advance the model by the same edge.
    task automatic tick(input logic r, input logic s, input logic sp, input logic pa);
        bit pulse;
        rst = r; start = s; stop = sp; pause = pa;
        @(posedge clk);
        pulse = m_busy && !pa && (m_el % TD == TD - 1);
        m_done = 1'b0;
        if (r) begin
            m_busy = 1'b0; m_el = 0; m_pl = 0;
        end else if (sp) begin
            m_busy = 1'b0; m_el = 0; m_pl = 0;
        end else if (!m_busy) begin
            if (s) begin
                m_busy = 1'b1; m_el = 0; m_pl = 0;
            end
        end else begin
            if (!pa) m_el++;
            if (pulse) begin
                m_pl++;
                if (m_pl == 3 * ST) begin
                    m_done = 1'b1; m_pl = 0; m_el = 0;
`ifndef SHIFT_SEQ_LOOP_EN
                    m_busy = 1'b0;
`endif
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b1);
        total++;
        if (vec !== 13'd0) begin bad++; $display("FAIL reset_vec got=%h exp=%h", vec, 13'd0); end
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        total++;
        if (vec !== exp_vec()) begin bad++; $display("FAIL reset_idle got=%h exp=%h", vec, exp_vec()); end
    endtask

    task automatic test_start_latency();
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        total++;
        if ({busy, mode1, phase} !== 4'b1101) begin bad++; $display("FAIL start_mode1 got=%b exp=%b", {busy, mode1, phase}, 4'b1101); end
        for (int i = 1; i <= 16; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            total++;
            if (vec !== exp_vec()) begin bad++; $display("FAIL start_model e%0d got=%h exp=%h", i, vec, exp_vec()); end
            total++;
            if (shift_en !== ((i % 4) == 3)) begin bad++; $display("FAIL start_pulse e%0d got=%b exp=%b", i, shift_en, ((i % 4) == 3)); end
        end
        total++;
        if ({phase, mode2, direction, step_cnt} !== 7'b10_1_1_000) begin
            bad++; $display("FAIL start_handoff got=%b exp=%b", {phase, mode2, direction, step_cnt}, 7'b1011000);
        end
        tick(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_full_run();
        int pulses = 0;
        int done_at = -1;
        logic [2:0] dirs = 3'b111;
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 52; i++) begin
            if (shift_en === 1'b1) pulses++;
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            total++;
            if (vec !== exp_vec()) begin bad++; $display("FAIL full_model e%0d got=%h exp=%h", i, vec, exp_vec()); end
            if (done === 1'b1 && done_at < 0) done_at = i;
            if (i == 1)  dirs[0] = direction;
            if (i == 17) dirs[1] = direction;
            if (i == 33) dirs[2] = direction;
            if (i == 48) begin
                total++;
`ifdef SHIFT_SEQ_LOOP_EN
                if ({busy, phase, direction} !== 4'b1010) begin bad++; $display("FAIL full_wrap got=%b exp=%b", {busy, phase, direction}, 4'b1010); end
`else
                if ({busy, phase} !== 3'b000) begin bad++; $display("FAIL full_idle got=%b exp=%b", {busy, phase}, 3'b000); end
`endif
            end
        end
        total++;
        if (pulses !== 12) begin bad++; $display("FAIL full_pulses got=%0d exp=%0d", pulses, 12); end
        total++;
        if (done_at !== 48) begin bad++; $display("FAIL full_done_edge got=%0d exp=%0d", done_at, 48); end
        total++;
        if (dirs !== 3'b010) begin bad++; $display("FAIL full_dirs got=%b exp=%b", dirs, 3'b010); end
        tick(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_pause();
        int done_at = -1;
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 4; i <= 13; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b1);
            total++;
            if ({shift_en, step_cnt} !== 4'b0_000 || vec !== exp_vec()) begin
                bad++; $display("FAIL pause_hold e%0d got=%h exp=%h", i, vec, exp_vec());
            end
        end
        pause = 1'b0;
        #1;
        total++;
        if ({shift_en, step_cnt} !== 4'b1_000) begin bad++; $display("FAIL pause_release got=%b exp=%b", {shift_en, step_cnt}, 4'b1000); end
        for (int i = 14; i <= 70 && done_at < 0; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            total++;
            if (vec !== exp_vec()) begin bad++; $display("FAIL pause_model e%0d got=%h exp=%h", i, vec, exp_vec()); end
            if (done === 1'b1) done_at = i;
        end
        total++;
        if (done_at !== 58) begin bad++; $display("FAIL pause_done_edge got=%0d exp=%0d", done_at, 58); end
        tick(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_stop();
        int pulses = 0;
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
        start = 1'b1; stop = 1'b1;
        #1;
        total++;
        if (shift_en !== 1'b1) begin bad++; $display("FAIL stop_pending got=%b exp=%b", shift_en, 1'b1); end
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        total++;
        if ({busy, phase, step_cnt, direction, done} !== 7'd0) begin
            bad++; $display("FAIL stop_idle got=%b exp=%b", {busy, phase, step_cnt, direction, done}, 7'd0);
        end
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            if (shift_en === 1'b1 || phase !== 2'd0) pulses++;
        end
        total++;
        if (pulses !== 0) begin bad++; $display("FAIL stop_quiet got=%0d exp=%0d", pulses, 0); end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 24; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if ({phase, step_cnt} !== 5'b10_010) begin bad++; $display("FAIL rstmid_pre got=%b exp=%b", {phase, step_cnt}, 5'b10010); end
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        total++;
        if (vec !== 13'd0) begin bad++; $display("FAIL rstmid_vec got=%h exp=%h", vec, 13'd0); end
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            if (shift_en !== 1'b0 || busy !== 1'b0) pulses++;
        end
        total++;
        if (pulses !== 0) begin bad++; $display("FAIL rstmid_quiet got=%0d exp=%0d", pulses, 0); end
    endtask

    task automatic test_back_to_back();
        int seen = 0;
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 60 && seen == 0; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            if (done === 1'b1) seen = i;
        end
        total++;
        if (seen !== 48) begin bad++; $display("FAIL b2b_done got=%0d exp=%0d", seen, 48); end
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        total++;
        if ({busy, phase, step_cnt, done} !== 7'b1_01_000_0 || vec !== exp_vec()) begin
            bad++; $display("FAIL b2b_restart got=%h exp=%h", vec, exp_vec());
        end
        tick(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic pa = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) == 0) pa = ~pa;
            tick(($urandom_range(0, 299) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 89) == 0), pa);
            total++;
            if (vec !== exp_vec()) begin bad++; $display("FAIL random c%0d got=%h exp=%h", i, vec, exp_vec()); end
        end
    endtask

    initial begin
        test_reset();
        test_start_latency();
        test_full_run();
        test_pause();
        test_stop();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
